onebit_program_sequencer: RTL
=============================

Name: onebit_program_sequencer

Overview:
Controller that owns the one-bit NAND processor's load/run lifecycle. It clears the processor, takes 13-bit instruction words from an upstream source over a valid/ready handshake, serializes them onto the processor's bit-serial load path (load enable plus data bit), then releases the processor to execute for a programmed number of cycles. At the end of the run it captures the 7-bit output register. It sits between the host/config interface and the processor core.

Parameters:
INSTR_BITS, 13, instruction word width
SLOT_BITS, 14, load cycles per word on the serial path (INSTR_BITS data bits, then zero padding)
MAX_WORDS, 1000, instruction memory depth; words beyond this are an error
WCNT_W, 10, width of word counter
RUN_W, 16, width of run-cycle budget

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  begin clear/load/run sequence; sampled in IDLE/DONE/ERROR only
word_data  in  INSTR_BITS  instruction word, bit 0 shifted first
word_valid  in  1  word_data valid
word_last  in  1  qualifies final word of program
word_ready  out  1  sequencer accepts word this cycle
run_cycles  in  RUN_W  execution budget, latched at start; 0 = run until stop
stop  in  1  end RUN early
proc_reset  out  1  active-high reset to processor
proc_load_en  out  1  processor load enable
proc_load_bit  out  1  serial instruction bit
proc_out  in  7  processor output register
result  out  7  proc_out captured at end of run
words_loaded  out  WCNT_W  words accepted in current program
running  out  1  processor executing
done  out  1  one-cycle pulse at end of run
error  out  2  sticky: 01 underrun, 10 overflow; cleared on start

Behaviour:
- States: IDLE, CLEAR, WAIT_FIRST, SHIFT, RUN, DONE, ERROR.
- Reset (reset=0, sync): state IDLE. proc_reset=1. All other outputs 0, counters 0. Reset overrides everything, including mid-load or mid-run.
- IDLE: proc_reset=1. On start=1: latch run_cycles, clear error/words_loaded, then go to CLEAR.
- CLEAR: exactly 1 cycle. proc_reset=1, proc_load_en=0. Then go to WAIT_FIRST.
- WAIT_FIRST: proc_reset=0, word_ready=1, proc_load_en=0. Stay until word_valid. On transfer: load shift register, words_loaded=1, bit index k=0, go to SHIFT.
- SHIFT: proc_load_en=1 every cycle. proc_load_bit = word[k] for k<INSTR_BITS, else 0. k increments per cycle, 0..SLOT_BITS-1.
  - word_ready=1 only at k=SLOT_BITS-1, and only if the current word was not last.
  - At k=SLOT_BITS-1 with current word last: go to RUN next cycle; proc_load_en falls to 0.
  - At k=SLOT_BITS-1, not last, word_valid=1: load next word, k=0, words_loaded+1. proc_load_en stays high, so the stream is gapless.
  - At k=SLOT_BITS-1, not last, word_valid=0: error=01, go to ERROR. The processor's load counters reset only on a rising load enable, so a gap cannot be resumed.
  - Accepting a word when words_loaded==MAX_WORDS: error=10, go to ERROR, word not shifted.
- Load latency: the first bit appears the cycle after the first transfer. A program of N words holds proc_load_en high for exactly N*SLOT_BITS consecutive cycles.
- RUN: proc_load_en=0, proc_reset=0, running=1. Down-counter starts at the latched budget and decrements each cycle.
  - Budget B>0: exactly B RUN cycles, then DONE.
  - Budget 0: stays in RUN until stop.
  - stop=1 in RUN: go to DONE next cycle, whichever comes first.
- DONE: 1 cycle. done=1, result<=proc_out sampled this cycle, running=0. Then IDLE; result holds.
- ERROR: proc_reset=1, proc_load_en=0. Stays until start, which behaves as from IDLE.
- start outside IDLE/DONE/ERROR is ignored. stop outside RUN is ignored.
- word_ready is never asserted in CLEAR, RUN, DONE, ERROR, or IDLE.

Test Plan:
1. Reset held 3 cycles mid-SHIFT -> proc_reset=1, proc_load_en=0, words_loaded=0, state IDLE.
2. start; one word 13'h1A5 with last, run_cycles=5 -> CLEAR 1 cycle; proc_load_bit sequence 1,0,1,0,0,1,0,1,1,0,0,0,0,0 over 14 cycles with proc_load_en=1; running=1 for exactly 5 cycles; done pulse; result=proc_out.
3. Three words back-to-back, valid held high -> proc_load_en high 42 consecutive cycles; word_ready pulses at cycles 13 and 27 of the stream; words_loaded=3.
4. Second word withheld at slot boundary -> error=01, proc_load_en drops next cycle, proc_reset=1; next start clears error.
5. run_cycles=0, stop asserted after 100 RUN cycles -> done exactly 1 cycle after stop; result captured.
6. MAX_WORDS=4 build, 5 words sent -> error=10 on the 5th transfer attempt; words_loaded=4.

Source files
------------

// File: rtl/onebit_program_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onebit_program_sequencer
// Description : Owns the clear/load/run lifecycle of the one-bit NAND
//               processor. Accepts instruction words over valid/ready,
//               streams them bit-serially onto the processor load path
//               without gaps, runs the processor for a latched budget and
//               captures its output register at the end of the run.
// Revision    : 1.0 - initial release
// ============================================================================
module onebit_program_sequencer #(
    parameter int INSTR_BITS = 13,
    parameter int SLOT_BITS  = 14,
    parameter int MAX_WORDS  = 1000,
    parameter int WCNT_W     = 10,
    parameter int RUN_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [INSTR_BITS-1:0] word_data,
    input  logic                  word_valid,
    input  logic                  word_last,
    output logic                  word_ready,
    input  logic [RUN_W-1:0]      run_cycles,
    input  logic                  stop,
    output logic                  proc_reset,
    output logic                  proc_load_en,
    output logic                  proc_load_bit,
    input  logic [6:0]            proc_out,
    output logic [6:0]            result,
    output logic [WCNT_W-1:0]     words_loaded,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            error
);

    localparam int              c_K_W    = $clog2(SLOT_BITS);
    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(SLOT_BITS - 1);
    localparam logic [c_K_W-1:0] c_K_PRE  = c_K_W'(SLOT_BITS - 2);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLEAR = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_RUN   = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;
    localparam logic [2:0] c_ST_ERROR = 3'd6;

    localparam logic [1:0] c_ERR_UNDERRUN = 2'b01;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'b10;

    logic [2:0]            r_state;
    logic [INSTR_BITS-1:0] r_shift;    // LSB is the bit currently on the load path
    logic [c_K_W-1:0]      r_k;        // bit slot within the current word
    logic                  r_last;
    logic [WCNT_W-1:0]     r_words;
    logic [RUN_W-1:0]      r_budget;
    logic [RUN_W-1:0]      r_cnt;
    logic [6:0]            r_result;
    logic [1:0]            r_error;
    logic                  r_proc_reset;
    logic                  r_load_en;
    logic                  r_ready;
    logic                  r_running;
    logic                  r_done;

    // Every output comes straight from a flop; each transition below sets the
    // output registers for the state being entered. The shift register is kept
    // zero outside SHIFT so the serial bit idles low, and zeros shifted in
    // after the data bits form the padding slot(s).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_k          <= '0;
            r_last       <= 1'b0;
            r_words      <= '0;
            r_budget     <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_error      <= '0;
            r_proc_reset <= 1'b1;
            r_load_en    <= 1'b0;
            r_ready      <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_ERROR, c_ST_DONE: begin
                    if (r_state == c_ST_DONE) begin
                        r_result <= proc_out;
                    end
                    if (start) begin
                        r_budget     <= run_cycles;
                        r_error      <= '0;
                        r_words      <= '0;
                        r_state      <= c_ST_CLEAR;
                        r_proc_reset <= 1'b1;
                    end else if (r_state == c_ST_DONE) begin
                        r_state      <= c_ST_IDLE;
                        r_proc_reset <= 1'b1;
                    end
                end

                c_ST_CLEAR: begin
                    r_state      <= c_ST_WAIT;
                    r_proc_reset <= 1'b0;
                    r_ready      <= 1'b1;
                end

                c_ST_WAIT: begin
                    if (word_valid) begin
                        r_shift   <= word_data;
                        r_last    <= word_last;
                        r_k       <= '0;
                        r_words   <= WCNT_W'(1);
                        r_state   <= c_ST_SHIFT;
                        r_ready   <= 1'b0;
                        r_load_en <= 1'b1;
                    end
                end

                c_ST_SHIFT: begin
                    if (r_k == c_K_LAST) begin
                        r_ready <= 1'b0;
                        if (r_last) begin
                            r_state   <= c_ST_RUN;
                            r_load_en <= 1'b0;
                            r_running <= 1'b1;
                            r_cnt     <= r_budget;
                            r_shift   <= '0;
                        end else if (word_valid && (r_words != WCNT_W'(MAX_WORDS))) begin
                            // Back-to-back word: load enable stays high, so
                            // the processor sees one continuous load burst.
                            r_shift <= word_data;
                            r_last  <= word_last;
                            r_k     <= '0;
                            r_words <= r_words + WCNT_W'(1);
                        end else begin
                            // A load gap cannot be resumed by the processor,
                            // and a word past the memory depth is dropped.
                            r_error      <= word_valid ? c_ERR_OVERFLOW : c_ERR_UNDERRUN;
                            r_state      <= c_ST_ERROR;
                            r_load_en    <= 1'b0;
                            r_proc_reset <= 1'b1;
                            r_shift      <= '0;
                        end
                    end else begin
                        r_shift <= r_shift >> 1;
                        r_k     <= r_k + c_K_W'(1);
                        r_ready <= (r_k == c_K_PRE) && !r_last;
                    end
                end

                c_ST_RUN: begin
                    if (stop || ((r_budget != '0) && (r_cnt == RUN_W'(1)))) begin
                        r_state   <= c_ST_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - RUN_W'(1);
                    end
                end

                default: begin
                    r_state      <= c_ST_IDLE;
                    r_proc_reset <= 1'b1;
                    r_load_en    <= 1'b0;
                    r_ready      <= 1'b0;
                    r_running    <= 1'b0;
                    r_shift      <= '0;
                end
            endcase
        end
    end

    assign word_ready    = r_ready;
    assign proc_reset    = r_proc_reset;
    assign proc_load_en  = r_load_en;
    assign proc_load_bit = r_shift[0];
    assign result        = r_result;
    assign words_loaded  = r_words;
    assign running       = r_running;
    assign done          = r_done;
    assign error         = r_error;

endmodule
`default_nettype wire
